dds_spi_master: RTL and testbench

SPI transmitter that programs the DDS core's frequency and phase-shift registers from the sys_clk domain. It drives spi_clk, spi_data, freq_cs and phaseshift_cs, matching the DDS receive side:
- Chip selects are active-high.
- Data is sampled on the rising edge of spi_clk and sent MSB first.
- The DDS loads the register on the falling edge of cs.

It accepts one command at a time through a valid/ready handshake. It sits between the host/control logic and the dds core.

---
 rtl/dds_spi_master.sv | 171 +++++++++++++++++
 tb/tb_dds_spi_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_spi_master.sv
// SPI transmitter that loads the DDS frequency or phase-shift register from the sys_clk domain.
// Handshake: a command transfers on the rising sys_clk edge where cmd_valid && cmd_ready; cmd_ready is high only in IDLE.
module dds_spi_master #(
  parameter int ACC_LENGTH   = 48,
  parameter int PHASE_LENGTH = 16,
  parameter int CLK_DIV      = 2,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_sel,
  input  logic [ACC_LENGTH-1:0] cmd_data,
  output logic                  spi_clk,
  output logic                  spi_data,
  output logic                  freq_cs,
  output logic                  phaseshift_cs,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state_o
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int BW      = $clog2(ACC_LENGTH + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_M1  = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_TAIL  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bits_q, bits_d;
  logic [ACC_LENGTH-1:0] shreg_q, shreg_d;
  logic                  sel_q, sel_d;
  logic                  spi_clk_q, spi_clk_d;
  logic                  spi_data_q, spi_data_d;
  logic                  freq_cs_q, freq_cs_d;
  logic                  ps_cs_q, ps_cs_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  last;
  logic                  cs_on;

  assign last = (cnt_q == '0);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bits_q     <= '0;
      shreg_q    <= '0;
      sel_q      <= 1'b0;
      spi_clk_q  <= 1'b0;
      spi_data_q <= 1'b0;
      freq_cs_q  <= 1'b0;
      ps_cs_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bits_q     <= bits_d;
      shreg_q    <= shreg_d;
      sel_q      <= sel_d;
      spi_clk_q  <= spi_clk_d;
      spi_data_q <= spi_data_d;
      freq_cs_q  <= freq_cs_d;
      ps_cs_q    <= ps_cs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // The word is MSB-aligned in the shift register so the bit on the wire is always shreg[top].
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    shreg_d = shreg_q;
    sel_d   = sel_q;
    if (state_q != S_IDLE && !last) begin
      cnt_d = cnt_q - CW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_SETUP;
          cnt_d   = HALF_M1;
          sel_d   = cmd_sel;
          if (cmd_sel) begin
            bits_d  = BW'(PHASE_LENGTH);
            shreg_d = ACC_LENGTH'(cmd_data[PHASE_LENGTH-1:0]) << (ACC_LENGTH - PHASE_LENGTH);
          end else begin
            bits_d  = BW'(ACC_LENGTH);
            shreg_d = cmd_data;
          end
        end
      end
      S_SETUP: begin
        if (last) begin
          state_d = S_HIGH;
          cnt_d   = HALF_M1;
        end
      end
      S_HIGH: begin
        if (last) begin
          cnt_d = HALF_M1;
          if (bits_q == BW'(1)) begin
            state_d = S_TAIL;
          end else begin
            state_d = S_LOW;
            shreg_d = shreg_q << 1;
            bits_d  = bits_q - BW'(1);
          end
        end
      end
      S_LOW: begin
        if (last) begin
          state_d = S_HIGH;
          cnt_d   = HALF_M1;
        end
      end
      S_TAIL: begin
        if (last) begin
          state_d = S_GAP;
          cnt_d   = GAP_M1;
        end
      end
      S_GAP: begin
        if (last) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so the registered pins line up with the state they belong to.
  always_comb begin
    cs_on      = (state_d == S_SETUP) || (state_d == S_HIGH) ||
                 (state_d == S_LOW)   || (state_d == S_TAIL);
    spi_clk_d  = (state_d == S_HIGH);
    freq_cs_d  = cs_on && !sel_d;
    ps_cs_d    = cs_on && sel_d;
    spi_data_d = ((state_d == S_SETUP) || (state_d == S_HIGH) || (state_d == S_LOW)) &&
                 shreg_d[ACC_LENGTH-1];
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_q == S_GAP) && (state_d == S_IDLE);
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign spi_clk       = spi_clk_q;
  assign spi_data      = spi_data_q;
  assign freq_cs       = freq_cs_q;
  assign phaseshift_cs = ps_cs_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dds_spi_master.sv
// Bench for dds_spi_master: one instance at CLK_DIV=2 and one at CLK_DIV=1, checked from captured pin traces.
module tb_dds_spi_master;

  localparam int GAP = 4;

  logic        sys_clk = 1'b0;
  logic        rst0, valid0, sel0, rst1, valid1, sel1;
  logic [47:0] data0, data1;
  logic        ready0, sclk0, sdat0, fcs0, pcs0, busy0, done0;
  logic        ready1, sclk1, sdat1, fcs1, pcs1, busy1, done1;
  logic [2:0]  dbg0, dbg1;

  always #5 sys_clk = ~sys_clk;

  dds_spi_master #(.ACC_LENGTH(48), .PHASE_LENGTH(16), .CLK_DIV(2), .GAP_CYCLES(GAP)) u_dut0 (
    .sys_clk(sys_clk), .rst(rst0), .cmd_valid(valid0), .cmd_ready(ready0), .cmd_sel(sel0),
    .cmd_data(data0), .spi_clk(sclk0), .spi_data(sdat0), .freq_cs(fcs0), .phaseshift_cs(pcs0),
    .busy(busy0), .done(done0), .dbg_state_o(dbg0));

  dds_spi_master #(.ACC_LENGTH(48), .PHASE_LENGTH(16), .CLK_DIV(1), .GAP_CYCLES(GAP)) u_dut1 (
    .sys_clk(sys_clk), .rst(rst1), .cmd_valid(valid1), .cmd_ready(ready1), .cmd_sel(sel1),
    .cmd_data(data1), .spi_clk(sclk1), .spi_data(sdat1), .freq_cs(fcs1), .phaseshift_cs(pcs1),
    .busy(busy1), .done(done1), .dbg_state_o(dbg1));

  typedef struct packed {
    logic clk;
    logic data;
    logic fcs;
    logic pcs;
    logic busy;
    logic done;
    logic ready;
  } samp_t;

  typedef struct {
    bit          d1;
    bit          sel;
    logic [47:0] data;
    logic [47:0] exp_word;
    int          exp_cs;
    int          exp_edges;
  } vec_t;

  samp_t tr[$];
  int    n_checks = 0;
  int    n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[47:0];
  endfunction

  function automatic samp_t sample(input bit d1);
    samp_t s;
    if (d1) s = '{clk: sclk1, data: sdat1, fcs: fcs1, pcs: pcs1, busy: busy1, done: done1, ready: ready1};
    else    s = '{clk: sclk0, data: sdat0, fcs: fcs0, pcs: pcs0, busy: busy0, done: done0, ready: ready0};
    return s;
  endfunction

  task automatic drive(input bit d1, input bit v, input bit s, input logic [47:0] d);
    if (d1) begin valid1 = v; sel1 = s; data1 = d; end
    else    begin valid0 = v; sel0 = s; data0 = d; end
  endtask

  // Reference view of one chip-select window: what a DDS receiver would see on its pins.
  function automatic void analyze(input bit sel, output int rise, output int fall, output int cs_cyc,
                                  output int edges, output logic [47:0] word, output int other_hi,
                                  output int data_bad, output int no_tog, output int done_idx);
    bit pc, pclk, pdat, c, o;
    rise = -1; fall = -1; cs_cyc = 0; edges = 0; word = '0;
    other_hi = 0; data_bad = 0; no_tog = 0; done_idx = -1;
    pc = 1'b0; pclk = 1'b0; pdat = 1'b0;
    for (int i = 0; i < tr.size(); i++) begin
      c = sel ? tr[i].pcs : tr[i].fcs;
      o = sel ? tr[i].fcs : tr[i].pcs;
      if (c && !pc && rise < 0) rise = i;
      if (!c && pc && fall < 0 && rise >= 0) fall = i;
      if (c && fall < 0) begin
        cs_cyc++;
        if (o) other_hi++;
        if (tr[i].clk && !pclk) begin
          edges++;
          word = {word[46:0], tr[i].data};
        end
        if (pc && tr[i].clk && tr[i].data != pdat) data_bad++;
        if (pc && tr[i].clk == pclk) no_tog++;
      end
      if (tr[i].done && fall >= 0 && done_idx < 0) done_idx = i;
      pc = c; pclk = tr[i].clk; pdat = tr[i].data;
    end
  endfunction

  task automatic xfer(input bit d1, input bit sel, input logic [47:0] data, input logic [47:0] exp_word,
                      input int exp_cs, input int exp_edges, input string tag);
    int rise, fall, cs_cyc, edges, other_hi, data_bad, no_tog, done_idx, wait_n, busy_n, done_n;
    logic [47:0] word;
    samp_t s;
    drive(d1, 1'b1, sel, data);
    wait_n = 0;
    s = sample(d1);
    while (!s.ready && wait_n < 500) begin
      @(negedge sys_clk);
      wait_n++;
      s = sample(d1);
    end
    check({tag, " ready_before_accept"}, 64'(s.ready), 64'(1));
    tr.delete();
    tr.push_back(s);
    @(negedge sys_clk);
    drive(d1, 1'b0, 1'($urandom_range(0, 1)), rnd48());
    repeat (exp_cs + GAP + 6) begin
      tr.push_back(sample(d1));
      @(negedge sys_clk);
    end
    analyze(sel, rise, fall, cs_cyc, edges, word, other_hi, data_bad, no_tog, done_idx);
    busy_n = 0; done_n = 0;
    foreach (tr[i]) begin
      if (tr[i].busy) busy_n++;
      if (tr[i].done) done_n++;
    end
    check({tag, " cs_rise"},    64'(rise),     64'(1));
    check({tag, " cs_cycles"},  64'(cs_cyc),   64'(exp_cs));
    check({tag, " edges"},      64'(edges),    64'(exp_edges));
    check({tag, " word"},       64'(word),     64'(exp_word));
    check({tag, " other_cs"},   64'(other_hi), 64'(0));
    check({tag, " data_stable"}, 64'(data_bad), 64'(0));
    check({tag, " done_after_fall"}, 64'(done_idx - fall), 64'(GAP));
    check({tag, " done_count"}, 64'(done_n),   64'(1));
    check({tag, " busy_cycles"}, 64'(busy_n),  64'(exp_cs + GAP));
    if (d1) check({tag, " clk_toggle"}, 64'(no_tog), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[3];
    samp_t s;
    int rise_f, fall_f, cs_f, edges_f, oth_f, bad_f, tog_f, done_f;
    int rise_p, fall_p, cs_p, edges_p, oth_p, bad_p, tog_p, done_p;
    int ready_idx, done_n, edges, hits;
    logic [47:0] word_f, word_p, d;
    bit pclk, sel, d1;
    int n, half;

    vecs[0] = '{d1: 1'b0, sel: 1'b0, data: 48'h0000_1234_5678, exp_word: 48'h0000_1234_5678, exp_cs: 194, exp_edges: 48};
    vecs[1] = '{d1: 1'b0, sel: 1'b1, data: 48'hFFFF_FFFF_A5C3, exp_word: 48'h0000_0000_A5C3, exp_cs: 66, exp_edges: 16};
    vecs[2] = '{d1: 1'b1, sel: 1'b1, data: 48'h0000_0000_0001, exp_word: 48'h0000_0000_0001, exp_cs: 33, exp_edges: 16};

    // Reset held with a pending command: nothing may start.
    rst0 = 1'b1; rst1 = 1'b1;
    drive(1'b0, 1'b1, 1'b0, rnd48());
    drive(1'b1, 1'b1, 1'b1, rnd48());
    repeat (3) begin
      @(negedge sys_clk);
      s = sample(1'b0);
      check("reset outputs dut0", 64'({s.clk, s.data, s.fcs, s.pcs, s.busy, s.done}), 64'(0));
      check("reset ready dut0", 64'(s.ready), 64'(1));
      s = sample(1'b1);
      check("reset outputs dut1", 64'({s.clk, s.data, s.fcs, s.pcs, s.busy, s.done, s.ready}), 64'(1));
    end
    rst0 = 1'b0; rst1 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    repeat (3) begin
      @(negedge sys_clk);
      s = sample(1'b0);
      check("post_reset idle", 64'({s.busy, s.fcs, s.pcs, s.ready}), 64'(1));
    end

    for (int i = 0; i < 3; i++) begin
      xfer(vecs[i].d1, vecs[i].sel, vecs[i].data, vecs[i].exp_word,
           vecs[i].exp_cs, vecs[i].exp_edges, $sformatf("vec%0d", i));
    end

    // Randomized commands, expectations from the wire-level rules.
    for (int i = 0; i < 6; i++) begin
      d1   = 1'($urandom_range(0, 1));
      sel  = 1'($urandom_range(0, 1));
      d    = rnd48();
      n    = sel ? 16 : 48;
      half = d1 ? 1 : 2;
      xfer(d1, sel, d, sel ? {32'h0, d[15:0]} : d, (2 * n + 1) * half, n, $sformatf("rnd%0d", i));
    end

    // Back-to-back: cmd_valid stays high across both commands.
    @(negedge sys_clk);
    drive(1'b0, 1'b1, 1'b0, 48'h1);
    tr.delete();
    tr.push_back(sample(1'b0));
    @(negedge sys_clk);
    drive(1'b0, 1'b1, 1'b1, 48'hABCD_EF01_8000);
    for (int i = 0; i < 300; i++) begin
      s = sample(1'b0);
      tr.push_back(s);
      if (s.pcs && valid0) drive(1'b0, 1'b0, 1'b0, rnd48());
      @(negedge sys_clk);
    end
    analyze(1'b0, rise_f, fall_f, cs_f, edges_f, word_f, oth_f, bad_f, tog_f, done_f);
    analyze(1'b1, rise_p, fall_p, cs_p, edges_p, word_p, oth_p, bad_p, tog_p, done_p);
    ready_idx = -1; done_n = 0;
    for (int i = 1; i < tr.size(); i++) begin
      if (tr[i].ready && ready_idx < 0) ready_idx = i;
      if (tr[i].done) done_n++;
    end
    check("b2b freq word", 64'(word_f), 64'(48'h1));
    check("b2b freq cs_cycles", 64'(cs_f), 64'(194));
    check("b2b phase word", 64'(word_p), 64'(48'h8000));
    check("b2b phase cs_cycles", 64'(cs_p), 64'(66));
    check("b2b accept at done", 64'(ready_idx), 64'(done_f));
    check("b2b fall_to_rise", 64'(rise_p - fall_f), 64'(GAP + 1));
    check("b2b done_count", 64'(done_n), 64'(2));
    check("b2b other_cs", 64'(oth_f + oth_p), 64'(0));

    // Reset after the 10th rising spi_clk edge of a frequency write.
    drive(1'b0, 1'b1, 1'b0, rnd48());
    @(negedge sys_clk);
    drive(1'b0, 1'b0, 1'b0, rnd48());
    edges = 0; pclk = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (sclk0 && !pclk) edges++;
      pclk = sclk0;
      if (edges == 10) break;
      @(negedge sys_clk);
    end
    check("abort reached 10 edges", 64'(edges), 64'(10));
    rst0 = 1'b1;
    @(negedge sys_clk);
    rst0 = 1'b0;
    s = sample(1'b0);
    check("abort outputs", 64'({s.clk, s.fcs, s.pcs, s.busy, s.done}), 64'(0));
    check("abort ready", 64'(s.ready), 64'(1));
    hits = 0;
    repeat (20) begin
      @(negedge sys_clk);
      s = sample(1'b0);
      if (s.done || s.fcs || s.pcs || s.busy) hits++;
    end
    check("abort quiet", 64'(hits), 64'(0));
    xfer(1'b0, 1'b1, 48'h0000_0000_1234, 48'h0000_0000_1234, 66, 16, "after_abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
